// File: rtl/adc_pkg.sv
// adc_pkg -- shared definitions for the ADC deserializer training controller.
//   State encoding of the training FSM, the ISERDES reset pulse length and
//   the number of bitslip-wait cycles ignored while the bitslip FSM spins up.
package adc_pkg;

    // Number of cycles rst_iserd is held high at the start of training.
    localparam int RST_SER_CYC = 4;

    // The bitslip FSM needs a couple of cycles to raise its running flag
    // after bs_init, so the flag is ignored for this many cycles.
    localparam int BS_SKIP_CYC = 2;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_RST_SER  = 4'd1;
    localparam logic [3:0] S_SETTLE   = 4'd2;
    localparam logic [3:0] S_SAMPLE   = 4'd3;
    localparam logic [3:0] S_DLY_STEP = 4'd4;
    localparam logic [3:0] S_BS_START = 4'd5;
    localparam logic [3:0] S_BS_WAIT  = 4'd6;
    localparam logic [3:0] S_CHECK    = 4'd7;
    localparam logic [3:0] S_NEXT     = 4'd8;
    localparam logic [3:0] S_DONE     = 4'd9;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/adc_train_cnt.sv
// adc_train_cnt -- loadable saturating up-counter.
//   clk, rst : clock, synchronous active-high reset (clears count)
//   ld       : load ld_val this cycle (has priority over inc)
//   ld_val   : value to load
//   inc      : increment by one; holds at all-ones instead of wrapping
//   cnt      : current count
module adc_train_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (ld)
            cnt <= ld_val;
        else if (inc && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/adc_train_ctrl.sv
// adc_train_ctrl -- sequences IODELAY/bitslip training over NCH ADC channels.
//   clk        : frame clock (single clock domain)
//   rst        : synchronous active-high reset
//   start      : one-cycle pulse, starts training (accepted in IDLE/DONE only)
//   dch_ok     : per-channel pattern-match status
//   bs_confrun : per-channel bitslip FSM running flag
//   ramp_ok    : per-channel ramp-increment check
//   rst_iserd  : ISERDES/IODELAY reset, all channels
//   dly_adj    : one-hot delay-increment pulse
//   bs_init    : one-hot bitslip start pulse
//   busy       : training in progress
//   done       : training finished, held until next start or rst
//   ch_fail    : sticky per-channel failure flags
//   ch_taps    : low 5 bits of the tap count of the current/last channel
module adc_train_ctrl
    import adc_pkg::*;
#(
    parameter int NCH        = 8,
    parameter int SETTLE_CYC = 16,
    parameter int MAX_TAPS   = 32,
    parameter int BS_TMO     = 256,
    parameter int CHECK_CYC  = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [NCH-1:0] dch_ok,
    input  logic [NCH-1:0] bs_confrun,
    input  logic [NCH-1:0] ramp_ok,
    output logic           rst_iserd,
    output logic [NCH-1:0] dly_adj,
    output logic [NCH-1:0] bs_init,
    output logic           busy,
    output logic           done,
    output logic [NCH-1:0] ch_fail,
    output logic [4:0]     ch_taps
);

    localparam int CW = $clog2(max3(SETTLE_CYC, BS_TMO, CHECK_CYC) + RST_SER_CYC) + 1;
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    // The settle window is measured from the triggering event (reset release
    // or the delay-step cycle itself), so SETTLE occupies SETTLE_CYC-1 cycles
    // and consecutive dly_adj pulses land SETTLE_CYC+1 cycles apart.
    localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_CYC >= 2) ? SETTLE_CYC - 2 : 0);
    localparam logic [CW-1:0] RST_LAST    = CW'(RST_SER_CYC - 1);
    localparam logic [CW-1:0] BS_LAST     = CW'(BS_TMO - 1);
    localparam logic [CW-1:0] BS_SKIP     = CW'(BS_SKIP_CYC);
    localparam logic [CW-1:0] CHK_LAST    = CW'(CHECK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST    = IW'(NCH - 1);
    localparam logic [5:0]    TAPS_MAX    = 6'(MAX_TAPS);

    logic [3:0]    state, state_nxt;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic [5:0]    taps;
    logic          fail_set;
    logic [NCH-1:0] sel;

    // One counter serves every timed state; it restarts at 0 on each state change.
    adc_train_cnt #(.W(CW)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .ld     (state_nxt != state),
        .ld_val ('0),
        .inc    (1'b1),
        .cnt    (cnt)
    );

    // Tap counter: cleared at the start of each channel, bumped per delay step.
    adc_train_cnt #(.W(6)) u_taps (
        .clk    (clk),
        .rst    (rst),
        .ld     ((state == S_RST_SER) || (state == S_NEXT)),
        .ld_val ('0),
        .inc    (state == S_DLY_STEP),
        .cnt    (taps)
    );

    always_comb begin
        state_nxt = state;
        fail_set  = 1'b0;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_RST_SER;
            S_RST_SER:  if (cnt == RST_LAST) state_nxt = S_SETTLE;
            S_SETTLE:   if (cnt >= SETTLE_LAST) state_nxt = S_SAMPLE;
            S_SAMPLE: begin
                if (dch_ok[idx])
                    state_nxt = S_BS_START;
                else if (taps == TAPS_MAX) begin
                    fail_set  = 1'b1;
                    state_nxt = S_NEXT;
                end else
                    state_nxt = S_DLY_STEP;
            end
            S_DLY_STEP: state_nxt = S_SETTLE;
            S_BS_START: state_nxt = S_BS_WAIT;
            S_BS_WAIT: begin
                // Alignment wins over timeout if both happen on the last cycle.
                if ((cnt >= BS_SKIP) && !bs_confrun[idx])
                    state_nxt = S_CHECK;
                else if (cnt >= BS_LAST) begin
                    fail_set  = 1'b1;
                    state_nxt = S_NEXT;
                end
            end
            S_CHECK: begin
                if (!ramp_ok[idx]) begin
                    fail_set  = 1'b1;
                    state_nxt = S_NEXT;
                end else if (cnt >= CHK_LAST)
                    state_nxt = S_NEXT;
            end
            S_NEXT:     state_nxt = (idx == IDX_LAST) ? S_DONE : S_SETTLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            ch_fail <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_RST_SER) begin
                idx     <= '0;
                ch_fail <= '0;
            end
            if (fail_set)
                ch_fail[idx] <= 1'b1;
            if ((state == S_NEXT) && (idx != IDX_LAST))
                idx <= idx + 1'b1;
        end
    end

    assign sel       = NCH'(1) << idx;
    assign rst_iserd = (state == S_RST_SER);
    assign dly_adj   = (state == S_DLY_STEP) ? sel : '0;
    assign bs_init   = (state == S_BS_START) ? sel : '0;
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);
    assign ch_taps   = taps[4:0];

endmodule

// File: tb/tb_adc_train_ctrl.sv
module tb_adc_train_ctrl;

    localparam int NCH = 2;
    localparam int SC  = 16;

    logic           clk = 1'b0;
    logic           rst, start;
    logic [NCH-1:0] dch_ok, bs_confrun, ramp_ok;
    logic           rst_iserd, busy, done;
    logic [NCH-1:0] dly_adj, bs_init, ch_fail;
    logic [4:0]     ch_taps;

    adc_train_ctrl #(.NCH(NCH), .SETTLE_CYC(SC), .MAX_TAPS(32), .BS_TMO(256), .CHECK_CYC(64)) dut (
        .clk(clk), .rst(rst), .start(start), .dch_ok(dch_ok), .bs_confrun(bs_confrun),
        .ramp_ok(ramp_ok), .rst_iserd(rst_iserd), .dly_adj(dly_adj), .bs_init(bs_init),
        .busy(busy), .done(done), .ch_fail(ch_fail), .ch_taps(ch_taps)
    );

    always #5 clk = ~clk;

    typedef struct {
        int fail; int taps_bs0; int taps_end; int dly0; int dly1; int nbs; int nrst; int gap;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // ---------------- channel model (ADC front-end behaviour) ----------------
    logic [1:0] cfg_dch = 2'b11;
    bit         cfg_cr_stuck0 = 0;
    bit         cfg_drop = 0;
    int         cfg_dch0_after = 0;
    int         bs_cd [NCH];
    int         rcd = 0, npulse0 = 0;
    bit         hit0 = 0, ramp_restore = 0;

    initial begin
        bs_confrun = '0;
        ramp_ok    = '1;
        dch_ok     = '1;
        for (int i = 0; i < NCH; i++) bs_cd[i] = 0;
    end

    always @(negedge clk) begin
        if (start && !busy) begin
            hit0 = 0; npulse0 = 0; rcd = 0; ramp_restore = 0;
            bs_confrun = '0; ramp_ok = '1;
            for (int i = 0; i < NCH; i++) bs_cd[i] = 0;
        end else begin
            // bitslip FSM: running flag up after bs_init, drops 5 cycles later
            for (int i = 0; i < NCH; i++) begin
                if (bs_init[i]) begin
                    bs_cd[i] = 5;
                    bs_confrun[i] = 1'b1;
                end else if (bs_cd[i] > 0) begin
                    bs_cd[i]--;
                    if (bs_cd[i] == 0 && !(i == 0 && cfg_cr_stuck0)) bs_confrun[i] = 1'b0;
                end
            end
            if (ramp_restore) begin
                ramp_ok[0] = 1'b1;
                ramp_restore = 0;
            end
            // ramp glitch lands on CHECK cycle 30 (CHECK starts 6 cycles after bs_init)
            if (bs_init[0] && cfg_drop) rcd = 36;
            else if (rcd > 0) begin
                rcd--;
                if (rcd == 0) begin
                    ramp_ok[0] = 1'b0;
                    ramp_restore = 1;
                end
            end
            if (dly_adj[0] && cfg_dch0_after > 0) begin
                npulse0++;
                if (npulse0 == cfg_dch0_after) hit0 = 1;
            end
        end
        dch_ok = cfg_dch | {1'b0, hit0};
    end

    // ---------------- monitor / scoreboard ----------------
    int cyc = 0, m_dly0 = 0, m_dly1 = 0, m_nbs = 0, m_nrst = 0;
    int last0 = -1, last1 = -1, first_bs = -1, m_gap = 0, m_taps_bs0 = 0;
    bit done_q = 0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (start && !busy) begin
            m_dly0 = 0; m_dly1 = 0; m_nbs = 0; m_nrst = 0;
            last0 = -1; last1 = -1; first_bs = -1; m_gap = 0; m_taps_bs0 = 0;
        end else if (!rst) begin
            if (rst_iserd) m_nrst++;
            if (|{dly_adj, bs_init}) chk("one_hot", $countones({dly_adj, bs_init}), 1);
            if (dly_adj[0]) begin
                if (last0 >= 0) chk("dly0_spacing", cyc - last0, SC + 1);
                last0 = cyc; m_dly0++;
            end
            if (dly_adj[1]) begin
                if (last1 >= 0) chk("dly1_spacing", cyc - last1, SC + 1);
                last1 = cyc; m_dly1++;
            end
            if (bs_init[0]) begin
                m_taps_bs0 = int'(ch_taps);
                first_bs = cyc;
            end
            if (bs_init[1] && first_bs >= 0) m_gap = cyc - first_bs;
            if (|bs_init) m_nbs++;
        end
        if (done && !done_q) begin
            if (sbq.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e = sbq.pop_front();
                chk("ch_fail",  int'(ch_fail), e.fail);
                chk("taps_bs0", m_taps_bs0, e.taps_bs0);
                chk("taps_end", int'(ch_taps), e.taps_end);
                chk("dly0_cnt", m_dly0, e.dly0);
                chk("dly1_cnt", m_dly1, e.dly1);
                chk("bs_cnt",   m_nbs, e.nbs);
                chk("rst_len",  m_nrst, e.nrst);
                chk("bs_gap",   m_gap, e.gap);
                chk("busy_at_done", int'(busy), 0);
            end
        end
        done_q = done;
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start();
        @(posedge clk) #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rst_iserd"}, int'(rst_iserd), 0);
        chk({tag, "_dly_adj"},   int'(dly_adj), 0);
        chk({tag, "_bs_init"},   int'(bs_init), 0);
        chk({tag, "_busy"},      int'(busy), 0);
        chk({tag, "_done"},      int'(done), 0);
        chk({tag, "_ch_fail"},   int'(ch_fail), 0);
        chk({tag, "_ch_taps"},   int'(ch_taps), 0);
    endtask

    task automatic run(input exp_t e, input int extra_start);
        bit got;
        sbq.push_back(e);
        pulse_start();
        chk("start_done_clr",  int'(done), 0);
        chk("start_rst_iserd", int'(rst_iserd), 1);
        got = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk) #1;
            if (extra_start > 0 && i == extra_start) start = 1'b1;
            else start = 1'b0;
            if (done) begin got = 1; break; end
        end
        start = 1'b0;
        if (!got) chk("done_timeout", 0, 1);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        exp_t e;
        bit   seen;
        rst = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // all channels lock immediately
        e = '{fail:0, taps_bs0:0, taps_end:0, dly0:0, dly1:0, nbs:2, nrst:4, gap:87};
        run(e, 0);
        // channel 0 locks after 7 delay steps; stray start mid-run is ignored
        cfg_dch = 2'b10; cfg_dch0_after = 7;
        e = '{fail:0, taps_bs0:7, taps_end:0, dly0:7, dly1:0, nbs:2, nrst:4, gap:87};
        run(e, 30);
        // channel 1 never locks: 32 steps then fail
        cfg_dch = 2'b01; cfg_dch0_after = 0;
        e = '{fail:2, taps_bs0:0, taps_end:0, dly0:0, dly1:32, nbs:1, nrst:4, gap:0};
        run(e, 0);
        // bitslip on channel 0 never finishes: timeout, channel 1 still trained
        cfg_dch = 2'b11; cfg_cr_stuck0 = 1;
        e = '{fail:1, taps_bs0:0, taps_end:0, dly0:0, dly1:0, nbs:2, nrst:4, gap:274};
        run(e, 0);
        // one-cycle ramp error at CHECK cycle 30 on channel 0
        cfg_cr_stuck0 = 0; cfg_drop = 1;
        e = '{fail:1, taps_bs0:0, taps_end:0, dly0:0, dly1:0, nbs:2, nrst:4, gap:54};
        run(e, 0);
        cfg_drop = 0;

        // reset while waiting for bitslip
        pulse_start();
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk) #1;
            if (bs_init[0]) begin seen = 1; break; end
        end
        if (!seen) chk("bs_init_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk) #1 chk_zero("midrst");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        e = '{fail:0, taps_bs0:0, taps_end:0, dly0:0, dly1:0, nbs:2, nrst:4, gap:87};
        run(e, 0);

        chk("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adc_train_ctrl.md
ADC_TRAIN_CTRL -- requirements
Module: adc_train_ctrl

Interface
REQ-001 Parameter NCH, default 8, number of deserialized ADC channels sequenced.
REQ-002 Parameter SETTLE_CYC, default 16, clk cycles waited after any reset release or delay step before sampling status.
REQ-003 Parameter MAX_TAPS, default 32, maximum delay increments per channel before failure.
REQ-004 Parameter BS_TMO, default 256, clk cycles allowed for bitslip alignment to finish.
REQ-005 Parameter CHECK_CYC, default 64, consecutive ramp_ok cycles needed to pass.
REQ-006 clk  in  1  frame clock (FCO domain); the block has one clock; reset is synchronous and active-high.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 start  in  1  single-cycle pulse; begins training of all channels.
REQ-009 dch_ok  in  NCH  per-channel pattern-match status.
REQ-010 bs_confrun  in  NCH  per-channel bitslip FSM running flag.
REQ-011 ramp_ok  in  NCH  per-channel ramp-increment check.
REQ-012 rst_iserd  out  1  ISERDES/IODELAY reset to all channels.
REQ-013 dly_adj  out  NCH  one-hot delay-increment pulse.
REQ-014 bs_init  out  NCH  one-hot bitslip start pulse.
REQ-015 busy  out  1  training in progress.
REQ-016 done  out  1  training finished; held until next start or rst.
REQ-017 ch_fail  out  NCH  sticky per-channel failure flags.
REQ-018 ch_taps  out  5  tap count reached on the channel currently or last trained.

Function
REQ-019 FSM states: IDLE, RST_SER, SETTLE, SAMPLE, DLY_STEP, BS_START, BS_WAIT, CHECK, NEXT, DONE.
REQ-020 IDLE -> RST_SER on start; start ignored in every state except IDLE and DONE.
REQ-021 RST_SER: rst_iserd high exactly 4 cycles, channel index cleared to 0, ch_fail cleared, then SETTLE.
REQ-022 SETTLE: wait SETTLE_CYC cycles, then SAMPLE.
REQ-023 SAMPLE: dch_ok[idx]=1 -> BS_START; else tap count == MAX_TAPS -> set ch_fail[idx], NEXT; else DLY_STEP.
REQ-024 DLY_STEP: dly_adj[idx] high one cycle, tap count +1, -> SETTLE.
REQ-025 BS_START: bs_init[idx] high one cycle, timeout counter cleared, -> BS_WAIT.
REQ-026 BS_WAIT: skip first 2 cycles, then bs_confrun[idx]=0 -> CHECK; counter reaching BS_TMO first -> set ch_fail[idx], NEXT.
REQ-027 CHECK: counter increments while ramp_ok[idx]=1; any ramp_ok[idx]=0 -> set ch_fail[idx], NEXT; count == CHECK_CYC -> NEXT.
REQ-028 NEXT: idx == NCH-1 -> DONE; else idx+1, tap count cleared, -> SETTLE (no ISERDES reset between channels).
REQ-029 DONE: done=1, busy=0; start -> RST_SER with done cleared same cycle.
REQ-030 busy=1 in all states except IDLE and DONE.
REQ-031 dly_adj and bs_init never high simultaneously and never on more than one bit.
REQ-032 Counters saturate, never wrap; tap counter 6 bits internally, ch_taps shows low 5 bits.

Reset
REQ-033 rst (any state, mid-training included) -> IDLE next cycle; outputs: rst_iserd=0, dly_adj=0, bs_init=0, busy=0, done=0, ch_fail=0, ch_taps=0.
REQ-034 rst has priority over start in the same cycle.

Structure
REQ-035 State encoding and the RST_SER length constant (4) live in shared package adc_pkg.
REQ-036 One sub-module natural: adc_train_cnt, a loadable saturating counter reused for settle, timeout and check counting.

Verification
REQ-037 NCH=2, dch_ok forced 1, bs_confrun drops 5 cycles after bs_init, ramp_ok=1 -> no dly_adj pulse, done after both channels, ch_fail=00.
REQ-038 dch_ok[0] rises after 7th dly_adj pulse -> exactly 7 pulses spaced SETTLE_CYC+1 apart, ch_taps=7.
REQ-039 dch_ok[1] stuck 0 -> 32 dly_adj[1] pulses, ch_fail=10, channel 0 still trained.
REQ-040 bs_confrun[0] stuck 1 -> ch_fail[0] set after 256 wait cycles, training continues on channel 1.
REQ-041 ramp_ok[0] low one cycle at CHECK cycle 30 -> ch_fail[0]=1.
REQ-042 rst asserted in BS_WAIT -> next cycle all outputs zero, state IDLE; start restarts with 4-cycle rst_iserd.
